// File: rtl/package_array_packer_pkg.sv
// rtl/package_array_packer_pkg.sv - shared widths, element type and packer state encoding
package my_package_pkg;

    localparam int WIDTHFP = 8;
    localparam int WIDTHFU = 4;
    localparam int WIDTHD  = 16;

    typedef logic [WIDTHFP-1:0] elem_t;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } packer_state_e;

endpackage

// File: rtl/package_array_packer_if.sv
// rtl/package_array_packer_if.sv - word-in / frame-out handshake bundle for the array packer
interface package_array_packer_if #(
    parameter int WIDTHFP = my_package_pkg::WIDTHFP,
    parameter int WIDTHFU = my_package_pkg::WIDTHFU,
    parameter int WIDTHD  = my_package_pkg::WIDTHD
);
    logic                       in_valid;
    logic                       in_ready;
    logic [WIDTHFP-1:0]         in_data;
    logic                       in_last;
    logic                       out_valid;
    logic                       out_ready;
    logic [WIDTHFP-1:0]         f [WIDTHFU-1:0];
    logic                       e [WIDTHFU-1:0];
    logic [WIDTHFP*WIDTHFU-1:0] f_flat;
    logic [WIDTHD-1:0]          d;

    // Packer side: consumes words, produces frames.
    modport master (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, f, e, f_flat, d
    );

    // Environment side: word source plus frame consumer.
    modport slave (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, f, e, f_flat, d
    );
endinterface

// File: rtl/package_array_packer.sv
// rtl/package_array_packer.sv - packs a word stream into numbered frames of package-sized arrays
module package_array_packer
    import my_package_pkg::*;
#(
    parameter int WIDTHFP = my_package_pkg::WIDTHFP,
    parameter int WIDTHFU = my_package_pkg::WIDTHFU,
    parameter int WIDTHD  = my_package_pkg::WIDTHD
) (
    input  logic                  clk,
    input  logic                  rst_n,
    package_array_packer_if.master bus
);
    localparam int IDX_W = $clog2(WIDTHFU);
    localparam logic [0:0] ST_FILL = 1'(FILL);
    localparam logic [0:0] ST_HOLD = 1'(HOLD);

    logic [0:0]         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTHFP-1:0] f_q [WIDTHFU-1:0];
    logic [WIDTHFP-1:0] f_d [WIDTHFU-1:0];
    logic               e_q [WIDTHFU-1:0];
    logic               e_d [WIDTHFU-1:0];
    logic [WIDTHD-1:0]  d_q, d_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        f_d     = f_q;
        e_d     = e_q;
        d_d     = d_q;
        if (state_q == ST_FILL) begin
            if (bus.in_valid) begin
                f_d[idx_q] = bus.in_data;
                e_d[idx_q] = 1'b1;
                if (idx_q == IDX_W'(WIDTHFU-1) || bus.in_last) begin
                    state_d = ST_HOLD;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
        end else if (bus.out_ready) begin
            // Clearing on handoff is what makes unwritten slots of a short frame read 0.
            state_d = ST_FILL;
            d_d     = d_q + WIDTHD'(1);
            for (int i = 0; i < WIDTHFU; i++) begin
                f_d[i] = '0;
                e_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FILL;
            idx_q   <= '0;
            d_q     <= '0;
            for (int i = 0; i < WIDTHFU; i++) begin
                f_q[i] <= '0;
                e_q[i] <= 1'b0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            d_q     <= d_d;
            f_q     <= f_d;
            e_q     <= e_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_FILL);
    assign bus.out_valid = (state_q == ST_HOLD);
    assign bus.d         = d_q;

    for (genvar g = 0; g < WIDTHFU; g++) begin : g_flat
        assign bus.f[g]                          = f_q[g];
        assign bus.e[g]                          = e_q[g];
        assign bus.f_flat[g*WIDTHFP +: WIDTHFP]  = f_q[g];
    end

endmodule
